// File: rtl/dcache_pkg.sv
// Shared constants for the N-way data cache: FSM state codes, access size codes
// and helpers that derive the tag/index/offset widths from the geometry.
package dcache_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOOKUP  = 3'd1;
   localparam logic [2:0] ST_WB      = 3'd2;
   localparam logic [2:0] ST_RF_REQ  = 3'd3;
   localparam logic [2:0] ST_RF_WAIT = 3'd4;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   function automatic int off_w(input int block_w);
      return $clog2(block_w / 8);
   endfunction

   function automatic int idx_w(input int set_count);
      return $clog2(set_count);
   endfunction

   function automatic int tag_w(input int addr_w, input int set_count, input int block_w);
      return addr_w - idx_w(set_count) - off_w(block_w);
   endfunction

endpackage

// File: rtl/dcache_plru_tree.sv
// Combinational tree pseudo-LRU for one set: walks the heap-ordered tree to find
// the victim, and flips every node on a touched way's path to point away from it.
module plru_tree #(
   parameter int N = 4
) (
   input  logic [N-2:0]         i_tree,
   input  logic [$clog2(N)-1:0] i_touch_way,
   output logic [$clog2(N)-1:0] o_victim,
   output logic [N-2:0]         o_tree_next
);

   localparam int LVL = $clog2(N);

   // A node bit of 0 sends the victim search to the left (lower-numbered) subtree.
   always_comb begin : victim_walk
      int node;
      o_victim = '0;
      node     = 0;
      for (int l = 0; l < LVL; l++) begin
         o_victim[LVL-1-l] = i_tree[node];
         node = 2 * node + 1 + int'(i_tree[node]);
      end
   end

   always_comb begin : touch_walk
      int node;
      o_tree_next = i_tree;
      node        = 0;
      for (int l = 0; l < LVL; l++) begin
         o_tree_next[node] = ~i_touch_way[LVL-1-l];
         node = 2 * node + 1 + int'(i_touch_way[LVL-1-l]);
      end
   end

endmodule

// File: rtl/dcache_nway.sv
// N-way set-associative write-back, write-allocate data cache with an internal
// writeback/refill engine; misses replay through LOOKUP once the line is filled.
module dcache_nway
   import dcache_pkg::*;
#(
   parameter int N         = 4,
   parameter int SET_COUNT = 16,
   parameter int BLOCK_W   = 512,
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64
) (
   input  logic               i_clk,
   input  logic               i_arst_n,
   input  logic               i_req_valid,
   output logic               o_req_ready,
   input  logic               i_req_we,
   input  logic [1:0]         i_req_size,
   input  logic [ADDR_W-1:0]  i_req_addr,
   input  logic [DATA_W-1:0]  i_req_wdata,
   output logic               o_resp_valid,
   output logic [DATA_W-1:0]  o_resp_rdata,
   output logic               o_store_addr_ma,
   output logic               o_mem_req_valid,
   input  logic               i_mem_req_ready,
   output logic               o_mem_req_we,
   output logic [ADDR_W-1:0]  o_mem_req_addr,
   output logic [BLOCK_W-1:0] o_mem_req_wblock,
   input  logic               i_mem_resp_valid,
   input  logic [BLOCK_W-1:0] i_mem_resp_block
);

   localparam int OFF_W = off_w(BLOCK_W);
   localparam int IDX_W = idx_w(SET_COUNT);
   localparam int TAG_W = tag_w(ADDR_W, SET_COUNT, BLOCK_W);
   localparam int WAY_W = $clog2(N);
   localparam int WRD_W = OFF_W - 3;

   logic [2:0]        state_q, state_d;
   logic              req_we_q, req_we_d;
   logic [1:0]        req_size_q, req_size_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
   logic [WAY_W-1:0]  victim_q, victim_d;

   logic [TAG_W-1:0]   tag_q   [SET_COUNT][N];
   logic [BLOCK_W-1:0] data_q  [SET_COUNT][N];
   logic               valid_q [SET_COUNT][N];
   logic               dirty_q [SET_COUNT][N];
   logic [N-2:0]       plru_q  [SET_COUNT];

   logic [IDX_W-1:0]   idx;
   logic [TAG_W-1:0]   req_tag;
   logic [WRD_W-1:0]   word_sel;
   logic [2:0]         byte_off;
   logic               hit, free, misalign;
   logic [WAY_W-1:0]   hit_way, free_way, plru_victim;
   logic [N-2:0]       plru_next;
   logic [7:0]         size_mask, byte_mask;
   logic [DATA_W-1:0]  bit_mask, wdata_sh, old_word, new_word;
   logic [BLOCK_W-1:0] hit_line, new_line;
   logic               hit_wr, fill_wr, plru_wr;

   assign idx      = req_addr_q[OFF_W +: IDX_W];
   assign req_tag  = req_addr_q[ADDR_W-1 -: TAG_W];
   assign word_sel = req_addr_q[OFF_W-1:3];
   assign byte_off = req_addr_q[2:0];

   assign o_req_ready = (state_q == ST_IDLE);

   // Descending scan so the lowest-numbered matching / invalid way wins.
   always_comb begin
      hit      = 1'b0;
      hit_way  = '0;
      free     = 1'b0;
      free_way = '0;
      for (int w = N - 1; w >= 0; w--) begin
         if (valid_q[idx][w] && (tag_q[idx][w] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[idx][w]) begin
            free     = 1'b1;
            free_way = WAY_W'(w);
         end
      end
   end

   plru_tree #(.N(N)) u_plru (
      .i_tree      (plru_q[idx]),
      .i_touch_way (hit_way),
      .o_victim    (plru_victim),
      .o_tree_next (plru_next)
   );

   always_comb begin
      misalign = req_we_q && (((req_size_q == SZ_H) && byte_off[0]) ||
                              ((req_size_q == SZ_W) && (byte_off[1:0] != 2'b00)) ||
                              ((req_size_q == SZ_D) && (byte_off != 3'b000)));
      case (req_size_q)
         SZ_B:    size_mask = 8'h01;
         SZ_H:    size_mask = 8'h03;
         SZ_W:    size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
      byte_mask = size_mask << byte_off;
      bit_mask  = '0;
      for (int b = 0; b < 8; b++) bit_mask[b*8 +: 8] = {8{byte_mask[b]}};
      wdata_sh = req_wdata_q << {byte_off, 3'b000};
      hit_line = data_q[idx][hit_way];
      old_word = hit_line[int'(word_sel)*DATA_W +: DATA_W];
      new_word = (old_word & ~bit_mask) | (wdata_sh & bit_mask);
      new_line = hit_line;
      new_line[int'(word_sel)*DATA_W +: DATA_W] = new_word;
   end

   always_comb begin
      state_d          = state_q;
      req_we_d         = req_we_q;
      req_size_d       = req_size_q;
      req_addr_d       = req_addr_q;
      req_wdata_d      = req_wdata_q;
      victim_d         = victim_q;
      o_resp_valid     = 1'b0;
      o_resp_rdata     = '0;
      o_store_addr_ma  = 1'b0;
      o_mem_req_valid  = 1'b0;
      o_mem_req_we     = 1'b0;
      o_mem_req_addr   = '0;
      o_mem_req_wblock = '0;
      hit_wr           = 1'b0;
      fill_wr          = 1'b0;
      plru_wr          = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_req_valid) begin
               req_we_d    = i_req_we;
               req_size_d  = i_req_size;
               req_addr_d  = i_req_addr;
               req_wdata_d = i_req_wdata;
               state_d     = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            if (misalign) begin
               o_resp_valid    = 1'b1;
               o_store_addr_ma = 1'b1;
               state_d         = ST_IDLE;
            end else if (hit) begin
               o_resp_valid = 1'b1;
               o_resp_rdata = old_word;
               hit_wr       = req_we_q;
               plru_wr      = 1'b1;
               state_d      = ST_IDLE;
            end else begin
               victim_d = free ? free_way : plru_victim;
               state_d  = (valid_q[idx][victim_d] && dirty_q[idx][victim_d]) ? ST_WB : ST_RF_REQ;
            end
         end
         ST_WB: begin
            o_mem_req_valid  = 1'b1;
            o_mem_req_we     = 1'b1;
            o_mem_req_addr   = {tag_q[idx][victim_q], idx, {OFF_W{1'b0}}};
            o_mem_req_wblock = data_q[idx][victim_q];
            if (i_mem_req_ready) state_d = ST_RF_REQ;
         end
         ST_RF_REQ: begin
            o_mem_req_valid = 1'b1;
            o_mem_req_addr  = {req_tag, idx, {OFF_W{1'b0}}};
            if (i_mem_req_ready) state_d = ST_RF_WAIT;
         end
         ST_RF_WAIT: begin
            if (i_mem_resp_valid) begin
               fill_wr = 1'b1;
               state_d = ST_LOOKUP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q     <= ST_IDLE;
         req_we_q    <= 1'b0;
         req_size_q  <= '0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         victim_q    <= '0;
      end else begin
         state_q     <= state_d;
         req_we_q    <= req_we_d;
         req_size_q  <= req_size_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         victim_q    <= victim_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         for (int s = 0; s < SET_COUNT; s++) begin
            plru_q[s] <= '0;
            for (int w = 0; w < N; w++) begin
               valid_q[s][w] <= 1'b0;
               dirty_q[s][w] <= 1'b0;
            end
         end
      end else begin
         if (fill_wr) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
         end
         if (hit_wr) dirty_q[idx][hit_way] <= 1'b1;
         if (plru_wr) plru_q[idx] <= plru_next;
      end
   end

   // Tag and data storage carry no reset; valid bits gate their use.
   always_ff @(posedge i_clk) begin
      if (fill_wr) begin
         data_q[idx][victim_q] <= i_mem_resp_block;
         tag_q[idx][victim_q]  <= req_tag;
      end else if (hit_wr) begin
         data_q[idx][hit_way] <= new_line;
      end
   end

endmodule

// File: tb/tb_dcache_nway.sv
// Bench for dcache_nway: directed scenarios plus random traffic checked against an
// architectural memory image (the cache must be transparent) and a backing store.
module tb_dcache_nway;

   logic         i_clk, i_arst_n;
   logic         i_req_valid, o_req_ready, i_req_we;
   logic [1:0]   i_req_size;
   logic [63:0]  i_req_addr, i_req_wdata, o_resp_rdata;
   logic         o_resp_valid, o_store_addr_ma;
   logic         o_mem_req_valid, i_mem_req_ready, o_mem_req_we;
   logic [63:0]  o_mem_req_addr;
   logic [511:0] o_mem_req_wblock, i_mem_resp_block;
   logic         i_mem_resp_valid;

   dcache_nway #(.N(4), .SET_COUNT(16), .BLOCK_W(512), .ADDR_W(64), .DATA_W(64)) dut (
      .i_clk            (i_clk),
      .i_arst_n         (i_arst_n),
      .i_req_valid      (i_req_valid),
      .o_req_ready      (o_req_ready),
      .i_req_we         (i_req_we),
      .i_req_size       (i_req_size),
      .i_req_addr       (i_req_addr),
      .i_req_wdata      (i_req_wdata),
      .o_resp_valid     (o_resp_valid),
      .o_resp_rdata     (o_resp_rdata),
      .o_store_addr_ma  (o_store_addr_ma),
      .o_mem_req_valid  (o_mem_req_valid),
      .i_mem_req_ready  (i_mem_req_ready),
      .o_mem_req_we     (o_mem_req_we),
      .o_mem_req_addr   (o_mem_req_addr),
      .o_mem_req_wblock (o_mem_req_wblock),
      .i_mem_resp_valid (i_mem_resp_valid),
      .i_mem_resp_block (i_mem_resp_block)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [511:0] arch    [longint];
   logic [511:0] backing [longint];
   logic [64:0]  mem_log [$];

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] init_line(input longint la);
      logic [511:0] l;
      for (int w = 0; w < 8; w++) l[w*64 +: 64] = {la[31:0], 8'hC3, 16'(w * 4099), 8'(w)};
      return l;
   endfunction

   function automatic logic [511:0] arch_line(input longint la);
      return arch.exists(la) ? arch[la] : init_line(la);
   endfunction

   function automatic logic [511:0] back_line(input longint la);
      return backing.exists(la) ? backing[la] : init_line(la);
   endfunction

   task automatic do_reset();
      @(negedge i_clk);
      i_arst_n = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      i_arst_n = 1'b1;
      arch.delete();
      foreach (backing[k]) arch[k] = backing[k];
   endtask

   // Drives one request and services the memory side until the response pulse.
   task automatic do_req(input logic we, input logic [1:0] size, input logic [63:0] addr,
                         input logic [63:0] wdata, output logic [63:0] rdata, output logic ma,
                         output int lat, output int n_mem, output int rf_to_resp);
      int guard, delay, rf_at;
      logic pending;
      longint paddr;
      i_req_valid = 1'b1;
      i_req_we    = we;
      i_req_size  = size;
      i_req_addr  = addr;
      i_req_wdata = wdata;
      guard = 0;
      while (!o_req_ready && guard < 20) begin
         @(posedge i_clk);
         @(negedge i_clk);
         guard++;
      end
      chk("accept_ready", o_req_ready, 1'b1);
      @(posedge i_clk);
      @(negedge i_clk);
      i_req_valid = 1'b0;
      lat = 0; n_mem = 0; rf_to_resp = -1; rf_at = -1;
      rdata = '0; ma = 1'b0; pending = 1'b0; delay = 0; paddr = 0;
      for (int c = 1; c <= 200; c++) begin
         i_mem_req_ready  = 1'b0;
         i_mem_resp_valid = 1'b0;
         i_mem_resp_block = '0;
         if (o_resp_valid) begin
            lat   = c;
            rdata = o_resp_rdata;
            ma    = o_store_addr_ma;
            break;
         end
         if (pending) begin
            if (delay == 0) begin
               i_mem_resp_valid = 1'b1;
               i_mem_resp_block = back_line(paddr);
               pending = 1'b0;
               rf_at   = c;
            end else delay--;
         end else if (o_mem_req_valid) begin
            if ($urandom_range(1, 0) == 1) begin
               i_mem_req_ready = 1'b1;
               n_mem++;
               mem_log.push_back({o_mem_req_we, o_mem_req_addr});
               if (o_mem_req_we) begin
                  chk("wb_data", o_mem_req_wblock, arch_line(longint'(o_mem_req_addr)));
                  backing[longint'(o_mem_req_addr)] = o_mem_req_wblock;
               end else begin
                  chk("rf_addr", o_mem_req_addr, addr & ~64'h3F);
                  pending = 1'b1;
                  paddr   = longint'(o_mem_req_addr);
                  delay   = $urandom_range(3, 0);
               end
            end
         end else if ($urandom_range(3, 0) == 0) begin
            i_mem_resp_valid = 1'b1;
            i_mem_resp_block = {16{$urandom}};
         end
         @(posedge i_clk);
         @(negedge i_clk);
      end
      i_mem_req_ready  = 1'b0;
      i_mem_resp_valid = 1'b0;
      if (lat == 0) chk("resp_timeout", 1'b0, 1'b1);
      if (rf_at >= 0) rf_to_resp = lat - rf_at;
   endtask

   // Issues an access and checks it against the architectural memory image.
   task automatic access(input logic we, input logic [1:0] size, input logic [63:0] addr,
                         input logic [63:0] wdata, output logic [63:0] rdata);
      logic [511:0] line;
      logic exp_ma, ma;
      int lat, n_mem, rf_to_resp, nb, off;
      longint la;
      la     = longint'(addr & ~64'h3F);
      nb     = 1 << size;
      off    = int'(addr[5:0]);
      exp_ma = we && ((off % nb) != 0);
      line   = arch_line(la);
      do_req(we, size, addr, wdata, rdata, ma, lat, n_mem, rf_to_resp);
      chk("store_ma", ma, exp_ma);
      if (!we) chk("load_data", rdata, line[(off / 8) * 64 +: 64]);
      if (we && !exp_ma) begin
         for (int b = 0; b < nb; b++) line[(off + b) * 8 +: 8] = wdata[b*8 +: 8];
         arch[la] = line;
      end
      if (n_mem == 0) chk("hit_latency", 32'(lat), 32'd1);
      else chk("refill_to_resp", 32'(rf_to_resp), 32'd1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0]  rd, a, wd;
      logic [511:0] exp_line;
      logic [1:0]   sz;
      int guard;
      i_arst_n = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_size = '0;
      i_req_addr = '0; i_req_wdata = '0; i_mem_req_ready = 1'b0;
      i_mem_resp_valid = 1'b0; i_mem_resp_block = '0;
      #12;
      chk("rst_ready", o_req_ready, 1'b1);
      chk("rst_resp_valid", o_resp_valid, 1'b0);
      chk("rst_rdata", o_resp_rdata, 64'h0);
      chk("rst_ma", o_store_addr_ma, 1'b0);
      chk("rst_mem_valid", o_mem_req_valid, 1'b0);
      chk("rst_mem_we", o_mem_req_we, 1'b0);
      chk("rst_mem_addr", o_mem_req_addr, 64'h0);
      chk("rst_mem_wblock", o_mem_req_wblock, 512'h0);
      @(negedge i_clk);
      i_arst_n = 1'b1;

      // Cold miss, then store/load hits on the filled line
      access(1'b0, 2'b11, 64'h1000, 64'h0, rd);
      exp_line = init_line(64'h1000);
      chk("cold_rdata", rd, exp_line[63:0]);
      chk("cold_mem_count", 32'(mem_log.size()), 32'd1);
      if (mem_log.size() == 1) chk("cold_rf_req", mem_log[0], {1'b0, 64'h1000});
      mem_log.delete();
      access(1'b1, 2'b11, 64'h1008, 64'hDEAD_BEEF_0000_0001, rd);
      access(1'b0, 2'b11, 64'h1008, 64'h0, rd);
      chk("sd_readback", rd, 64'hDEAD_BEEF_0000_0001);
      access(1'b1, 2'b00, 64'h100B, 64'hAA, rd);
      access(1'b0, 2'b11, 64'h1008, 64'h0, rd);
      chk("sb_readback", rd, 64'hDEAD_BEEF_AA00_0001);
      access(1'b1, 2'b10, 64'h1002, 64'h1234_5678, rd);
      access(1'b0, 2'b11, 64'h1000, 64'h0, rd);
      chk("hit_no_traffic", 32'(mem_log.size()), 32'd0);

      // Fill set 0, dirty way 0, touch ways 1..3, then miss on a fifth tag
      do_reset();
      for (int i = 0; i < 4; i++) access(1'b0, 2'b11, 64'(i) * 64'h400, 64'h0, rd);
      chk("fill_mem_count", 32'(mem_log.size()), 32'd4);
      access(1'b1, 2'b11, 64'h0, 64'h0123_4567_89AB_CDEF, rd);
      for (int i = 1; i < 4; i++) access(1'b0, 2'b11, 64'(i) * 64'h400, 64'h0, rd);
      mem_log.delete();
      access(1'b0, 2'b11, 64'h1000, 64'h0, rd);
      chk("evict_mem_count", 32'(mem_log.size()), 32'd2);
      if (mem_log.size() == 2) begin
         chk("evict_wb", mem_log[0], {1'b1, 64'h0});
         chk("evict_rf", mem_log[1], {1'b0, 64'h1000});
      end

      // Dirty every way, stall the writeback, then reset in the middle of it
      for (int i = 0; i < 4; i++)
         access(1'b1, 2'b11, (i == 0) ? 64'h1000 : 64'(i) * 64'h400, 64'(i) + 64'hF00D_0000, rd);
      exp_line = arch_line(64'h1000);
      @(posedge i_clk);
      @(negedge i_clk);
      i_req_valid = 1'b1; i_req_we = 1'b0; i_req_size = 2'b11; i_req_addr = 64'h1400;
      @(posedge i_clk);
      @(negedge i_clk);
      i_req_valid = 1'b0;
      guard = 0;
      while (!o_mem_req_valid && guard < 10) begin
         @(posedge i_clk);
         @(negedge i_clk);
         guard++;
      end
      chk("hold_ready_busy", o_req_ready, 1'b0);
      for (int i = 0; i < 6; i++) begin
         chk("hold_valid", o_mem_req_valid, 1'b1);
         chk("hold_we", o_mem_req_we, 1'b1);
         chk("hold_addr", o_mem_req_addr, 64'h1000);
         chk("hold_wblock", o_mem_req_wblock, exp_line);
         if (i < 5) begin
            @(posedge i_clk);
            @(negedge i_clk);
         end
      end
      i_arst_n = 1'b0;
      #1;
      chk("mid_rst_ready", o_req_ready, 1'b1);
      chk("mid_rst_mem_valid", o_mem_req_valid, 1'b0);
      chk("mid_rst_resp", o_resp_valid, 1'b0);
      @(posedge i_clk);
      @(negedge i_clk);
      i_arst_n = 1'b1;
      arch.delete();
      foreach (backing[k]) arch[k] = backing[k];
      mem_log.delete();
      access(1'b0, 2'b11, 64'h400, 64'h0, rd);
      chk("post_rst_mem_count", 32'(mem_log.size()), 32'd1);
      if (mem_log.size() == 1) chk("post_rst_rf", mem_log[0], {1'b0, 64'h400});

      // Random traffic over a few conflicting tags in two sets
      do_reset();
      for (int n = 0; n < 300; n++) begin
         sz = 2'($urandom_range(3, 0));
         a  = 64'($urandom_range(5, 0)) * 64'h400 + 64'($urandom_range(1, 0)) * 64'h40
              + 64'($urandom_range(63, 0));
         if ($urandom_range(3, 0) != 0) a = a & ~((64'h1 << sz) - 64'h1);
         wd = {$urandom, $urandom};
         access(1'($urandom_range(1, 0)), sz, a, wd, rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
